// File: rtl/tvbg_pkg.sv
// ----------------------------------------------------------------------------
// tvbg_pkg
// Shared definitions for the TV-B-Gone player: the carrier FSM state
// encoding and the default width of the CTC frequency/compare value. The
// code-sequencing controller uses the same width.
// ----------------------------------------------------------------------------
package tvbg_pkg;

    // Width of the CTC frequency/compare value.
    localparam int CTC_BITS = 8;

    // Carrier generator states.
    typedef enum logic [1:0] {
        S_OFF,      // LED dark
        S_FORCED,   // LED constant high, unmodulated
        S_HIGH,     // high half of a carrier period
        S_LOW       // low half of a carrier period
    } e_carrier_state;

endpackage : tvbg_pkg

// File: rtl/tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler
// Divides the system clock into counter ticks. tick_out is high in the last
// clock of every PRESCALE-clock window. With PRESCALE=1 it is high on every
// clock. clear_in holds the window counter at zero. While it is held there,
// the next tick comes PRESCALE clocks after clear_in is released.
// The delay timer also uses this block as its time base.
//
// Ports:
//   clock_in  - system clock, rising edge
//   reset_in  - asynchronous, active-high reset
//   clear_in  - hold the window counter at zero
//   tick_out  - one tick every PRESCALE clocks (combinational from counter)
// ----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clock_in,
    input  logic reset_in,
    input  logic clear_in,
    output logic tick_out
);

    localparam int                CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] presc_q;
    logic [CNT_W-1:0] presc_d;

    assign tick_out = (presc_q == LAST);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        presc_d = presc_q;
        if (clear_in || tick_out) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from before the edge, with no race between them.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule : tick_prescaler

// File: rtl/carrier_generator.sv
// ----------------------------------------------------------------------------
// carrier_generator
// Turns the controller's CTC interface into the modulated IR LED drive. It
// produces a square wave whose half-period is (value+1)*PRESCALE clocks. The
// output is constant high when forcing is requested and low when idle.
// All outputs are registered and reflect the state reached at each edge.
//
// Ports:
//   clock_in           - system clock, rising edge
//   reset_in           - asynchronous, active-high reset
//   enable_in          - carrier requested while high
//   forced_in          - constant-high output while high (beats enable_in)
//   wr_strobe_in       - one-cycle strobe, loads value_in
//   value_in           - half-period compare value
//   ir_out             - registered LED drive
//   period_strobe_out  - one-cycle pulse after each entry into the high phase
//   running_out        - high while modulating (S_HIGH or S_LOW)
// ----------------------------------------------------------------------------
module carrier_generator
    import tvbg_pkg::*;
#(
    parameter int CTC_BITS = tvbg_pkg::CTC_BITS,
    parameter int PRESCALE = 1
) (
    input  logic                clock_in,
    input  logic                reset_in,
    input  logic                enable_in,
    input  logic                forced_in,
    input  logic                wr_strobe_in,
    input  logic [CTC_BITS-1:0] value_in,
    output logic                ir_out,
    output logic                period_strobe_out,
    output logic                running_out
);

    e_carrier_state      state_q, state_d;
    logic [CTC_BITS-1:0] value_q;
    logic [CTC_BITS-1:0] half_q, half_d;
    logic                ir_q, strobe_q, running_q;
    logic                tick;
    logic                run_now, run_next;

    assign run_now  = (state_q == S_HIGH) || (state_q == S_LOW);
    assign run_next = (state_d == S_HIGH) || (state_d == S_LOW);

    // The prescaler advances only while modulation continues from one cycle
    // to the next. Any entry into or exit from modulation restarts its window.
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .clear_in (!(run_now && run_next)),
        .tick_out (tick)
    );

    always_comb begin
        state_d = state_q;
        half_d  = '0;
        unique case (state_q)
            S_OFF: begin
                if (forced_in)      state_d = S_FORCED;
                else if (enable_in) state_d = S_HIGH;
            end
            S_FORCED: begin
                if (!forced_in) state_d = enable_in ? S_HIGH : S_OFF;
            end
            S_HIGH, S_LOW: begin
                // A force or a disable beats a phase end in the same cycle.
                if (forced_in) begin
                    state_d = S_FORCED;
                end else if (!enable_in) begin
                    state_d = S_OFF;
                end else if (tick) begin
                    // Using >= means a newly written smaller value ends the
                    // current phase on the next tick instead of wrapping.
                    if (half_q >= value_q) begin
                        state_d = (state_q == S_HIGH) ? S_LOW : S_HIGH;
                    end else begin
                        half_d = half_q + CTC_BITS'(1);
                    end
                end else begin
                    half_d = half_q;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= S_OFF;
            value_q   <= '0;
            half_q    <= '0;
            ir_q      <= 1'b0;
            strobe_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            if (wr_strobe_in) value_q <= value_in;
            ir_q      <= (state_d == S_HIGH) || (state_d == S_FORCED);
            // Every entry into S_HIGH starts a period. This includes the
            // first entry from S_OFF or S_FORCED.
            strobe_q  <= (state_d == S_HIGH) && (state_q != S_HIGH);
            running_q <= run_next;
        end
    end

    assign ir_out            = ir_q;
    assign period_strobe_out = strobe_q;
    assign running_out       = running_q;

endmodule : carrier_generator

// File: tb/tb_carrier_generator.sv
// ----------------------------------------------------------------------------
// tb_carrier_generator
// Directed bench for carrier_generator. Instance A uses PRESCALE=1 and
// instance B uses PRESCALE=4. Both share the clock and reset. Inputs change
// 1 ns after a rising edge, and outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_carrier_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       en_a = 1'b0, frc_a = 1'b0, wr_a = 1'b0;
    logic [7:0] val_a = '0;
    logic       ir_a, ps_a, run_a;

    logic       en_b = 1'b0, frc_b = 1'b0, wr_b = 1'b0;
    logic [7:0] val_b = '0;
    logic       ir_b, ps_b, run_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    carrier_generator #(.CTC_BITS(8), .PRESCALE(1)) dut_a (
        .clock_in          (clk),
        .reset_in          (rst),
        .enable_in         (en_a),
        .forced_in         (frc_a),
        .wr_strobe_in      (wr_a),
        .value_in          (val_a),
        .ir_out            (ir_a),
        .period_strobe_out (ps_a),
        .running_out       (run_a)
    );

    carrier_generator #(.CTC_BITS(8), .PRESCALE(4)) dut_b (
        .clock_in          (clk),
        .reset_in          (rst),
        .enable_in         (en_b),
        .forced_in         (frc_b),
        .wr_strobe_in      (wr_b),
        .value_in          (val_b),
        .ir_out            (ir_b),
        .period_strobe_out (ps_b),
        .running_out       (run_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks all three outputs of instance A in one call.
    task automatic check_a(input string tag, input logic ir, input logic ps, input logic run);
        check({tag, ".ir"},  32'(ir_a),  32'(ir));
        check({tag, ".ps"},  32'(ps_a),  32'(ps));
        check({tag, ".run"}, 32'(run_a), 32'(run));
    endtask

    initial begin
        // ---------------- reset state ----------------
        #12;
        check_a("rst_a", 1'b0, 1'b0, 1'b0);
        check("rst_b.ir", 32'(ir_b), 0);
        check("rst_b.ps", 32'(ps_b), 0);
        check("rst_b.run", 32'(run_b), 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // ---------------- A: value 3, basic carrier ----------------
        wr_a = 1'b1; val_a = 8'd3;
        step();
        wr_a = 1'b0;
        check_a("idle_a", 1'b0, 1'b0, 1'b0);
        en_a = 1'b1;
        step();
        // After enable edge k: high for k%8 in 0..3, strobe at k%8==0.
        for (int k = 0; k < 24; k++) begin
            check_a($sformatf("v3_k%0d", k), ((k / 4) % 2) == 0, (k % 8) == 0, 1'b1);
            step();
        end
        en_a = 1'b0;
        step();
        check_a("v3_off", 1'b0, 1'b0, 1'b0);

        // ---------------- A: value 10, shortened to 2 mid-phase ----------------
        wr_a = 1'b1; val_a = 8'd10; en_a = 1'b1;
        step();                              // edge 0, half=0
        wr_a = 1'b0;
        for (int k = 1; k <= 7; k++) step(); // after edge 7, half=7
        check_a("mid_k7", 1'b1, 1'b0, 1'b1);
        wr_a = 1'b1; val_a = 8'd2;
        step();                              // edge 8: half=8, value now 2
        wr_a = 1'b0;
        check_a("mid_k8", 1'b1, 1'b0, 1'b1);
        step();                              // edge 9: 8>=2, phase ends
        // From edge 9: low 3, high 3, strobe when high begins.
        for (int j = 0; j < 12; j++) begin
            check_a($sformatf("mid_j%0d", j), ((j / 3) % 2) == 1, (j % 6) == 3, 1'b1);
            step();
        end

        // ---------------- A: forced while running ----------------
        frc_a = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            check_a($sformatf("frc_k%0d", k), 1'b1, 1'b0, 1'b0);
            step();
        end
        frc_a = 1'b0;   // enable still high
        step();
        for (int k = 0; k < 6; k++) begin
            check_a($sformatf("unfrc_k%0d", k), k < 3, k == 0, 1'b1);
            step();
        end
        en_a = 1'b0;
        step();
        check_a("unfrc_off", 1'b0, 1'b0, 1'b0);

        // ---------------- A: enable and forced together ----------------
        en_a = 1'b1; frc_a = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            check_a($sformatf("both_k%0d", k), 1'b1, 1'b0, 1'b0);
            step();
        end
        en_a = 1'b0; frc_a = 1'b0;
        step();
        check_a("both_off", 1'b0, 1'b0, 1'b0);

        // ---------------- A: value 0xFF loaded with enable ----------------
        wr_a = 1'b1; val_a = 8'hFF; en_a = 1'b1;
        step();
        wr_a = 1'b0;
        for (int k = 0; k <= 257; k++) begin
            check($sformatf("ff_k%0d.ir", k), 32'(ir_a), 32'(k < 256));
            step();
        end
        en_a = 1'b0;
        step();
        check_a("ff_off", 1'b0, 1'b0, 1'b0);

        // ---------------- B: PRESCALE 4, value 1 ----------------
        wr_b = 1'b1; val_b = 8'd1;
        step();
        wr_b = 1'b0;
        en_b = 1'b1;
        step();
        for (int k = 0; k <= 26; k++) begin
            check($sformatf("p4_k%0d.ir", k), 32'(ir_b), 32'(((k / 8) % 2) == 0));
            check($sformatf("p4_k%0d.ps", k), 32'(ps_b), 32'((k % 16) == 0));
            if (k < 26) step();
        end
        // Three clocks into the low phase that began at edge 24.
        en_b = 1'b0;
        step();
        check("p4_drop.ir", 32'(ir_b), 0);
        check("p4_drop.run", 32'(run_b), 0);
        check("p4_drop.ps", 32'(ps_b), 0);
        en_b = 1'b1;
        step();
        for (int k = 0; k < 10; k++) begin
            check($sformatf("p4_re_k%0d.ir", k), 32'(ir_b), 32'(k < 8));
            check($sformatf("p4_re_k%0d.ps", k), 32'(ps_b), 32'(k == 0));
            step();
        end
        en_b = 1'b0;
        step();

        // ---------------- A: asynchronous reset mid high phase ----------------
        wr_a = 1'b1; val_a = 8'd2; en_a = 1'b1;
        step();
        wr_a = 1'b0;
        step();
        check_a("pre_rst", 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        #1;             // well before the next rising edge
        check("arst.ir", 32'(ir_a), 0);
        check("arst.run", 32'(run_a), 0);
        en_a = 1'b0;
        #2;
        rst = 1'b0;
        step();
        check_a("post_rst", 1'b0, 1'b0, 1'b0);
        // value_q back at 0: toggle every clock with a strobe at each high.
        en_a = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            check_a($sformatf("v0_k%0d", k), (k % 2) == 0, (k % 2) == 0, 1'b1);
            step();
        end
        en_a = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_carrier_generator

// File: doc/carrier_generator.md
# carrier_generator

Produces the modulated IR LED drive for the TV-B-Gone player. It consumes the CTC interface of the code-sequencing controller (enable, forced, write strobe, 8-bit frequency value) and turns it into a square-wave carrier on a single registered output. The output is constant-high when forcing is requested and low otherwise. It sits between the controller and the IR LED output pin.

## Interface
- CTC_BITS, 8, width of the frequency/compare value
- PRESCALE, 1, clock cycles per counter tick (legal range ≥1); PRESCALE=1 disables prescaling
- clock_in  input  1  system clock, all logic on rising edge
- reset_in  input  1  asynchronous, active-high reset
- enable_in  input  1  carrier requested while high
- forced_in  input  1  drive output constant high while high (unmodulated carrier)
- wr_strobe_in  input  1  one-cycle strobe; load value_in
- value_in  input  CTC_BITS  half-period compare value
- ir_out  output  1  registered LED drive
- period_strobe_out  output  1  one-cycle pulse when a new carrier period starts (rising edge of ir_out in modulated mode)
- running_out  output  1  high in S_HIGH or S_LOW

## Operation
- Registers: value_r (CTC_BITS), presc_r (counts 0..PRESCALE-1), half_r (CTC_BITS), state_r.
- wr_strobe_in: value_r <= value_in at that edge, in any state. No effect on state or counters.
- tick = (presc_r == PRESCALE-1). presc_r wraps to 0 on tick and is held at 0 outside S_HIGH/S_LOW.
- On tick in S_HIGH/S_LOW:
  - if half_r >= value_r: toggle phase and set half_r <= 0;
  - else half_r <= half_r + 1.
  - Comparison is >=, so writing a value smaller than half_r mid-phase ends that phase on the next tick. There is no wrap-around.
- Half-period = (value_r+1)*PRESCALE clocks. Carrier frequency = f_clk / (2*(value_r+1)*PRESCALE).
- States (package enum):
  - S_OFF: ir_out 0.
    - forced_in → S_FORCED.
    - else enable_in → S_HIGH, with half_r and presc_r cleared.
  - S_FORCED: ir_out 1.
    - forced_in low and enable_in high → S_HIGH (counters cleared).
    - both low → S_OFF.
  - S_HIGH: ir_out 1. Phase end → S_LOW.
  - S_LOW: ir_out 0. Phase end → S_HIGH and pulse period_strobe_out.
  - From S_HIGH/S_LOW: forced_in → S_FORCED; enable_in low → S_OFF. Counters cleared in both cases.
- Priority: forced_in > enable_in. A disable overrides a phase end in the same cycle.
- The carrier always begins with a high phase. A partial phase is truncated on disable; it is not completed.
- Simultaneous wr_strobe_in and enable_in rising: the new value governs the first half-period.

## Timing
- Reset values: ir_out 0, period_strobe_out 0, running_out 0, state S_OFF, value_r 0, half_r 0, presc_r 0. Reset asserted mid-carrier drops ir_out immediately (asynchronously).
- ir_out, period_strobe_out and running_out are registered and reflect the state_r reached at an edge.
- Latency: enable_in or forced_in sampled high at edge k → ir_out 1 after edge k. Disable sampled at edge k → ir_out 0 after edge k.
- period_strobe_out:
  - pulses for 1 cycle after the edge entering S_HIGH from S_LOW;
  - also pulses on entry from S_OFF/S_FORCED, so the first period counts;
  - never pulses in S_FORCED.
- value_r=0, PRESCALE=1: ir_out toggles every clock (f_clk/2).

## Structure
- tvbg_pkg holds:
  - e_carrier_state enum (S_OFF, S_FORCED, S_HIGH, S_LOW);
  - CTC_BITS default, shared with the controller.
- One sub-module, tick_prescaler:
  - parameter PRESCALE; ports clear_in and tick_out;
  - reused by the delay timer for its time base.
- Target size about 150 lines including the prescaler.

## Test plan
- Reset, then value_in=3 strobed, PRESCALE=1, enable_in high at edge 10:
  - ir_out high for cycles 10-13 and low for 14-17, repeating;
  - period_strobe_out at cycles 10, 18, 26.
- PRESCALE=4, value=1: high 8 clocks, low 8 clocks. Drop enable_in 3 clocks into a low phase → ir_out 0 next cycle and running_out 0; re-enable → a fresh full 8-clock high phase.
- forced_in high while carrier running → ir_out 1 continuously from the next edge with no period strobes; release forced_in with enable_in still high → high phase restarts with a strobe.
- value=10, wait until half_r=7, then strobe value_in=2 → current phase ends on the next tick; following phases are 3 clocks each.
- Assert reset_in asynchronously mid high phase → ir_out 0 without waiting for a clock edge; after release, state S_OFF and value_r 0.
- value=0xFF with wr_strobe_in and enable_in on the same edge → first high phase is 256 clocks; enable and forced both high → forced behaviour.
